// File: rtl/mlt_pkg.sv
`default_nettype none
// ============================================================================
// Module : mlt_pkg
// Brief  : Shared FSM encoding and constants for the multiplier operand
//          sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package mlt_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_issue   = 2'd1;
    localparam logic [1:0] c_st_run     = 2'd2;
    localparam logic [1:0] c_st_capture = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_st_idle,
        ST_ISSUE   = c_st_issue,
        ST_RUN     = c_st_run,
        ST_CAPTURE = c_st_capture
    } state_t;

    localparam int c_width_default = 16;

    // Fixed part of the start-to-result latency: out_valid at t0 + 2*B + 1 + c_lat_base.
    localparam int c_lat_base = 4;

endpackage
`default_nettype wire

// File: rtl/mlt_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : mlt_operand_sequencer_if
// Brief  : Operand input, controller handshake and result output bundle.
//          MLT_SEQ_TIMEOUT_EN adds the err status signal.
// Rev    : 1.0  initial release
// ============================================================================
interface mlt_operand_sequencer_if
    import mlt_pkg::*;
#(
    parameter int WIDTH = c_width_default
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 start;
    logic                 ctrl_rst;
    logic                 lda;
    logic                 ldb;
    logic                 done;
    logic [WIDTH-1:0]     bus_data;
    logic [2*WIDTH-1:0]   prod_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic                 busy;
`ifdef MLT_SEQ_TIMEOUT_EN
    logic                 err;

    modport master (
        output in_valid, in_a, in_b, lda, ldb, done, prod_in, out_ready,
        input  in_ready, start, ctrl_rst, bus_data, out_valid, out_prod, busy, err
    );

    modport slave (
        input  in_valid, in_a, in_b, lda, ldb, done, prod_in, out_ready,
        output in_ready, start, ctrl_rst, bus_data, out_valid, out_prod, busy, err
    );
`else
    modport master (
        output in_valid, in_a, in_b, lda, ldb, done, prod_in, out_ready,
        input  in_ready, start, ctrl_rst, bus_data, out_valid, out_prod, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, lda, ldb, done, prod_in, out_ready,
        output in_ready, start, ctrl_rst, bus_data, out_valid, out_prod, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/mlt_op_fifo.sv
`default_nettype none
// ============================================================================
// Module : mlt_op_fifo
// Brief  : Small synchronous FIFO holding operand pairs; head is read
//          combinationally so it stays on the bus until popped.
// Rev    : 1.0  initial release
// ============================================================================
module mlt_op_fifo
    import mlt_pkg::*;
#(
    parameter int DATA_W = 2 * c_width_default,
    parameter int DEPTH  = 4
)
(
    input  wire              clk,
    input  wire              rst,
    input  wire              push,
    input  wire              pop,
    input  wire [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlt_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mlt_operand_sequencer
// Brief  : Buffers operand pairs, sequences the repeated-addition multiplier
//          controller and presents products. MLT_SEQ_TIMEOUT_EN adds a RUN
//          watchdog with sticky err.
// Rev    : 1.0  initial release
// ============================================================================
module mlt_operand_sequencer
    import mlt_pkg::*;
#(
    parameter int WIDTH = c_width_default,
    parameter int DEPTH = 4
)
(
    input  wire                    clk,
    input  wire                    resetn,
    mlt_operand_sequencer_if.slave sif
);

    state_t             r_state;
    state_t             w_next;
    logic               r_rst_hold;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_prod;
    logic               w_capture;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;

`ifdef MLT_SEQ_TIMEOUT_EN
    localparam int WD_W = WIDTH + 2;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'((64'd1 << (WIDTH + 1)) + 64'd7);

    logic [WD_W-1:0]    r_wd;
    logic               r_err;
    logic               w_timeout;
`endif

    // resetn is an active-high reset despite its name.
    assign sif.in_ready = !resetn && !w_full;
    assign w_push       = sif.in_valid && sif.in_ready;
    assign w_pop        = (r_state == ST_CAPTURE);

    mlt_op_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .wdata  ({sif.in_a, sif.in_b}),
        .rdata  (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign w_head_a = w_head[2*WIDTH-1:WIDTH];
    assign w_head_b = w_head[WIDTH-1:0];

    assign sif.bus_data = sif.lda ? w_head_a :
                          sif.ldb ? w_head_b : '0;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
`ifdef MLT_SEQ_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_RUN;
            end
            ST_RUN: begin
                // A pending result that is not being accepted blocks capture; done is held meanwhile.
                if (sif.done && (!r_out_valid || sif.out_ready)) begin
                    w_capture = 1'b1;
                    w_next    = ST_CAPTURE;
                end
`ifdef MLT_SEQ_TIMEOUT_EN
                else if (!sif.done && (r_wd == c_wd_last)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_CAPTURE;
                end
`endif
            end
            ST_CAPTURE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state     <= ST_IDLE;
            r_rst_hold  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
        end else begin
            r_state    <= w_next;
            r_rst_hold <= 1'b0;
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_prod  <= sif.prod_in;
            end else if (r_out_valid && sif.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MLT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != ST_RUN) begin
                r_wd <= '0;
            end else if (!sif.done) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sif.err = r_err;
`endif

    // Controller reset covers our own reset, the cycle after it, and every CAPTURE.
    assign sif.ctrl_rst  = resetn || r_rst_hold || (r_state == ST_CAPTURE);
    assign sif.start     = (r_state == ST_ISSUE);
    assign sif.out_valid = r_out_valid;
    assign sif.out_prod  = r_out_prod;
    assign sif.busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mlt_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mlt_operand_sequencer
// Brief  : Directed bench with a behavioural multiplier controller/datapath.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mlt_operand_sequencer;
    import mlt_pkg::*;

    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mlt_operand_sequencer_if #(.WIDTH(W)) sif ();

    mlt_operand_sequencer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sif    (sif.slave)
    );

    // Controller: load_A at t0+1, load_bp at t0+2, done from t0+2B+4 (+slow_extra) until ctrl_rst.
    int           m_cyc      = 0;
    bit           m_act      = 1'b0;
    logic [W-1:0] m_a        = '0;
    logic [W-1:0] m_b        = '0;
    int           slow_extra = 0;

    initial begin
        logic         s_rst, s_start, s_lda, s_ldb;
        logic [W-1:0] s_bus;
        sif.lda     = 1'b0;
        sif.ldb     = 1'b0;
        sif.done    = 1'b0;
        sif.prod_in = '0;
        forever begin
            @(negedge clk); #1;
            s_rst   = sif.ctrl_rst;
            s_start = sif.start;
            s_lda   = sif.lda;
            s_ldb   = sif.ldb;
            s_bus   = sif.bus_data;
            @(posedge clk); #1;
            if (s_rst) begin
                m_act = 1'b0;
                m_cyc = 0;
            end else if (m_act) begin
                m_cyc = m_cyc + 1;
                if (s_lda)      m_a = s_bus;
                else if (s_ldb) m_b = s_bus;
            end else if (s_start) begin
                m_act = 1'b1;
                m_cyc = 1;
            end
            sif.lda     = m_act && (m_cyc == 1);
            sif.ldb     = m_act && (m_cyc == 2);
            sif.done    = m_act && (m_cyc >= 4) && (m_cyc >= 2 * int'(m_b) + 4 + slow_extra);
            sif.prod_in = 32'(m_a) * 32'(m_b);
        end
    end

    int           cyc_cnt = 0;
    int           t_start = 0;
    int           n_start = 0;
    int           n_crst  = 0;
    logic [W-1:0] bus_a   = '0;
    logic [W-1:0] bus_b   = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        forever begin
            @(negedge clk); #1;
            if (sif.start) begin
                n_start = n_start + 1;
                t_start = cyc_cnt;
            end
            if (sif.ctrl_rst && !resetn) n_crst = n_crst + 1;
            if (sif.lda) bus_a = sif.bus_data;
            if (sif.ldb) bus_b = sif.bus_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $error("FAIL %s: observed timeout, expected event", tag);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int max);
        int k = 0;
        sif.in_valid = 1'b1;
        sif.in_a     = a;
        sif.in_b     = b;
        while (!sif.in_ready && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!sif.in_ready) timeout_fail("push_wait");
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int max);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sif.out_valid && k < max);
        if (!sif.out_valid) timeout_fail(tag);
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (!sif.done && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!sif.done) timeout_fail("done_wait");
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        resetn        = 1'b1;
        sif.in_valid  = 1'b0;
        sif.in_a      = '0;
        sif.in_b      = '0;
        sif.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  sif.in_ready,  1'b0);
        chk("rst_ctrl_rst",  sif.ctrl_rst,  1'b1);
        chk("rst_out_valid", sif.out_valid, 1'b0);
        chk("rst_out_prod",  sif.out_prod,  32'h0);
        chk("rst_start",     sif.start,     1'b0);
        chk("rst_busy",      sif.busy,      1'b0);
        chk("rst_bus_idle",  sif.bus_data,  16'h0);
`ifdef MLT_SEQ_TIMEOUT_EN
        chk("rst_err",       sif.err,       1'b0);
`endif
        resetn = 1'b0;
        #1;
        chk("rel_in_ready", sif.in_ready, 1'b1);
        chk("rel_ctrl_rst", sif.ctrl_rst, 1'b1);
        @(negedge clk);
        chk("rel_ctrl_rst_low", sif.ctrl_rst, 1'b0);

        // 3 x 4
        n_crst  = 0;
        n_start = 0;
        push(16'd3, 16'd4, 10);
        wait_result("t1_result", 100);
        chk("t1_prod",    sif.out_prod, 32'd12);
        chk("t1_latency", cyc_cnt - t_start, 2 * 4 + 1 + c_lat_base);
        chk("t1_bus_a",   bus_a, 16'd3);
        chk("t1_bus_b",   bus_b, 16'd4);
        @(negedge clk);
        chk("t1_out_clear", sif.out_valid, 1'b0);
        @(negedge clk);
        chk("t1_crst_once",  n_crst,  1);
        chk("t1_start_once", n_start, 1);

        // 0x00FF x 0
        n_start = 0;
        push(16'h00FF, 16'd0, 10);
        wait_result("t2_result", 100);
        chk("t2_prod",    sif.out_prod, 32'd0);
        chk("t2_latency", cyc_cnt - t_start, 5);
        @(negedge clk);
        chk("t2_start_once", n_start, 1);

        // Five pairs against a slow controller with the output stalled
        slow_extra    = 20;
        sif.out_ready = 1'b0;
        push(16'd2, 16'd3, 10);
        push(16'd5, 16'd5, 10);
        push(16'd7, 16'd1, 10);
        push(16'hFFFF, 16'd2, 10);
        chk("t3_full", sif.in_ready, 1'b0);
        push(16'd9, 16'd0, 200);
        chk("t3_first_valid", sif.out_valid, 1'b1);
        chk("t3_first_prod",  sif.out_prod,  32'd6);
        wait_done(200);
        repeat (5) @(negedge clk);
        chk("t4_done_held", sif.done,     1'b1);
        chk("t4_hold_prod", sif.out_prod, 32'd6);
        chk("t4_busy",      sif.busy,     1'b1);
        sif.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_second_valid", sif.out_valid, 1'b1);
        chk("t4_second_prod",  sif.out_prod,  32'd25);
        wait_result("t3_r3", 200);
        chk("t3_prod3", sif.out_prod, 32'd7);
        wait_result("t3_r4", 200);
        chk("t3_prod4", sif.out_prod, 32'h0001_FFFE);
        wait_result("t3_r5", 200);
        chk("t3_prod5", sif.out_prod, 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_idle", sif.busy, 1'b0);

        // Reset during RUN of 4 x 100 with a result pending and one entry queued
        slow_extra    = 0;
        sif.out_ready = 1'b0;
        push(16'd2, 16'd2, 10);
        push(16'd4, 16'd100, 10);
        push(16'd1, 16'd1, 10);
        repeat (30) @(negedge clk);
        chk("t5_pre_valid", sif.out_valid, 1'b1);
        chk("t5_pre_prod",  sif.out_prod,  32'd4);
        chk("t5_pre_busy",  sif.busy,      1'b1);
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", sif.out_valid, 1'b0);
        chk("t5_busy",      sif.busy,      1'b0);
        chk("t5_ctrl_rst",  sif.ctrl_rst,  1'b1);
        chk("t5_out_prod",  sif.out_prod,  32'd0);
        resetn = 1'b0;
        #1;
        chk("t5_in_ready", sif.in_ready, 1'b1);
        sif.out_ready = 1'b1;
        push(16'd6, 16'd7, 10);
        wait_result("t5_result", 100);
        chk("t5_prod",    sif.out_prod, 32'd42);
        chk("t5_latency", cyc_cnt - t_start, 2 * 7 + 1 + c_lat_base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
